id_ex_stage: RTL and testbench

Decode-to-execute stage that sits directly downstream of the 32x32 register file read ports (qa/qb) and upstream of the ALU.
- Resolves operands with full forwarding from EX, MEM and WB.
- Detects load-use hazards and asserts a stall toward PC and IF/ID.
- Owns the ID/EX pipeline register, including bubble insertion on stall and flush and hold on downstream back-pressure.

---
 rtl/id_ex_stage_pkg.sv | 44 ++++
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage_fwd_mux.sv | 51 +++++
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared constants and types for the ID/EX stage: datapath,
//               register-number and ALU-control widths, ALU operation
//               encodings, the zero-register number and the bubble control
//               fields loaded into the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 4;

    // r0 is hard-wired to zero; it is never a forwarding target
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // ALU operation encodings carried on aluc
    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_LUI = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7,
        ALU_SRA = 4'h8,
        ALU_SLT = 4'h9
    } aluc_e;

    // Control fields that define whether the EX slot holds real work
    typedef struct packed {
        logic valid;
        logic we;
        logic m2reg;
        logic wmem;
    } ctl_t;

    localparam ctl_t BUBBLE_CTL = '{valid: 1'b0, we: 1'b0, m2reg: 1'b0, wmem: 1'b0};

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between the decode stage and the ID/EX register.
//               d_* / rs / rt / use_* : decoded instruction from ID
//               e_*                   : registered ID/EX fields toward EX
//               master : the ID/EX stage (consumes d_*, drives e_*)
//               slave  : the surrounding pipeline (drives d_*, consumes e_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W,
    parameter int CW = CTRL_W
);

    // decode side
    logic          d_valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
    logic [RW-1:0] d_wn;
    logic          d_we;
    logic          d_m2reg;
    logic          d_wmem;
    logic [CW-1:0] d_aluc;
    logic          d_aluimm;
    logic [DW-1:0] d_imm;

    // execute side
    logic          e_valid;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    logic [DW-1:0] e_st;
    logic [DW-1:0] e_imm;
    logic [RW-1:0] e_wn;
    logic          e_we;
    logic          e_m2reg;
    logic          e_wmem;
    logic [CW-1:0] e_aluc;
    logic          e_aluimm;

    modport master (
        input  d_valid, rs, rt, use_rs, use_rt, d_wn, d_we, d_m2reg, d_wmem,
               d_aluc, d_aluimm, d_imm,
        output e_valid, e_a, e_b, e_st, e_imm, e_wn, e_we, e_m2reg, e_wmem,
               e_aluc, e_aluimm
    );

    modport slave (
        output d_valid, rs, rt, use_rs, use_rt, d_wn, d_we, d_m2reg, d_wmem,
               d_aluc, d_aluimm, d_imm,
        input  e_valid, e_a, e_b, e_st, e_imm, e_wn, e_we, e_m2reg, e_wmem,
               e_aluc, e_aluimm
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_fwd_mux
// Description : Operand resolver for one source register. Picks, in order,
//               zero for r0, the EX result, the MEM result, the WB data, and
//               finally the register-file read data.
// Ports       : rn             - source register number
//               rf_d           - register-file read data for rn
//               ex_we/wn/d     - EX bypass (ex_we already qualified by valid)
//               m_we/wn/d      - MEM bypass
//               w_we/wn/d      - WB bypass
//               q              - resolved operand
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W
) (
    input  wire logic [RW-1:0] rn,
    input  wire logic [DW-1:0] rf_d,
    input  wire logic          ex_we,
    input  wire logic [RW-1:0] ex_wn,
    input  wire logic [DW-1:0] ex_d,
    input  wire logic          m_we,
    input  wire logic [RW-1:0] m_wn,
    input  wire logic [DW-1:0] m_d,
    input  wire logic          w_we,
    input  wire logic [RW-1:0] w_wn,
    input  wire logic [DW-1:0] w_d,
    output logic      [DW-1:0] q
);

    // Youngest producer wins. The WB leg covers the register-file write that
    // lands on the same edge this stage samples qa/qb.
    always_comb begin
        q = rf_d;
        if (rn == '0) begin
            q = '0;
        end else if (ex_we && (ex_wn == rn)) begin
            q = ex_d;
        end else if (m_we && (m_wn == rn)) begin
            q = m_d;
        end else if (w_we && (w_wn == rn)) begin
            q = w_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute stage. Resolves rs/rt operands with full
//               EX/MEM/WB forwarding, detects load-use hazards, drives the
//               stall toward PC and IF/ID, and owns the ID/EX register with
//               bubble insertion (flush, load-use) and hold (ex_hold).
// Ports       : clk, clrn        - clock, asynchronous active-low reset
//               pipe (master)    - decoded ID instruction in, e_* fields out
//               qa, qb           - register-file read data for rs, rt
//               ex_r             - current EX ALU result
//               m_wn/m_we/m_d    - MEM stage destination and result
//               w_wn/w_we/w_d    - WB stage destination and data
//               flush            - kill the ID instruction
//               ex_hold          - EX busy, freeze ID/EX
//               stall            - hold PC and IF/ID (combinational)
//               cnt_lu/cnt_flush - event counters, only with STALL_CNT_EN
// Options     : STALL_CNT_EN - adds the cnt_lu / cnt_flush counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_W,
    parameter int CW = CTRL_W
) (
    input  wire logic          clk,
    input  wire logic          clrn,
    id_ex_stage_if.master      pipe,
    input  wire logic [DW-1:0] qa,
    input  wire logic [DW-1:0] qb,
    input  wire logic [DW-1:0] ex_r,
    input  wire logic [RW-1:0] m_wn,
    input  wire logic          m_we,
    input  wire logic [DW-1:0] m_d,
    input  wire logic [RW-1:0] w_wn,
    input  wire logic          w_we,
    input  wire logic [DW-1:0] w_d,
    input  wire logic          flush,
    input  wire logic          ex_hold,
    output logic               stall
`ifdef STALL_CNT_EN
    ,
    output logic      [31:0]   cnt_lu,
    output logic      [31:0]   cnt_flush
`endif
);

    // ID/EX register
    logic          r_valid;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_st;
    logic [DW-1:0] r_imm;
    logic [RW-1:0] r_wn;
    logic          r_we;
    logic          r_m2reg;
    logic          r_wmem;
    logic [CW-1:0] r_aluc;
    logic          r_aluimm;

    logic          w_ex_we;
    logic          w_lu;
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    // An EX slot only forwards if it carries a real, writing instruction
    assign w_ex_we = r_valid & r_we;

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
        .rn    (pipe.rs),
        .rf_d  (qa),
        .ex_we (w_ex_we),
        .ex_wn (r_wn),
        .ex_d  (ex_r),
        .m_we  (m_we),
        .m_wn  (m_wn),
        .m_d   (m_d),
        .w_we  (w_we),
        .w_wn  (w_wn),
        .w_d   (w_d),
        .q     (w_fwd_a)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
        .rn    (pipe.rt),
        .rf_d  (qb),
        .ex_we (w_ex_we),
        .ex_wn (r_wn),
        .ex_d  (ex_r),
        .m_we  (m_we),
        .m_wn  (m_wn),
        .m_d   (m_d),
        .w_we  (w_we),
        .w_wn  (w_wn),
        .w_d   (w_d),
        .q     (w_fwd_b)
    );

    // A load in EX has no data yet; a consumer in ID must wait one cycle and
    // will then pick the value up from the MEM bypass.
    assign w_lu = pipe.d_valid & r_valid & r_m2reg & r_we & (r_wn != REG_ZERO)
                & ((pipe.use_rs & (r_wn == pipe.rs)) | (pipe.use_rt & (r_wn == pipe.rt)));

    // A flush discards the ID instruction, so there is nothing to hold upstream
    assign stall = (w_lu | ex_hold) & ~flush;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            {r_valid, r_we, r_m2reg, r_wmem} <= BUBBLE_CTL;
            r_a      <= '0;
            r_b      <= '0;
            r_st     <= '0;
            r_imm    <= '0;
            r_wn     <= '0;
            r_aluc   <= '0;
            r_aluimm <= 1'b0;
        end else if (!ex_hold) begin
            // ex_hold freezes everything; a pending flush stays asserted
            // upstream until it is taken here.
            if (flush || w_lu) begin
                {r_valid, r_we, r_m2reg, r_wmem} <= BUBBLE_CTL;
                r_a      <= '0;
                r_b      <= '0;
                r_st     <= '0;
                r_imm    <= '0;
                r_wn     <= '0;
                r_aluc   <= '0;
                r_aluimm <= 1'b0;
            end else begin
                r_valid  <= pipe.d_valid;
                r_a      <= w_fwd_a;
                r_b      <= pipe.d_aluimm ? pipe.d_imm : w_fwd_b;
                r_st     <= w_fwd_b;
                r_imm    <= pipe.d_imm;
                r_wn     <= pipe.d_wn;
                // side effects are suppressed for an invalid slot
                r_we     <= pipe.d_we & pipe.d_valid;
                r_m2reg  <= pipe.d_m2reg;
                r_wmem   <= pipe.d_wmem & pipe.d_valid;
                r_aluc   <= pipe.d_aluc;
                r_aluimm <= pipe.d_aluimm;
            end
        end
    end

    assign pipe.e_valid  = r_valid;
    assign pipe.e_a      = r_a;
    assign pipe.e_b      = r_b;
    assign pipe.e_st     = r_st;
    assign pipe.e_imm    = r_imm;
    assign pipe.e_wn     = r_wn;
    assign pipe.e_we     = r_we;
    assign pipe.e_m2reg  = r_m2reg;
    assign pipe.e_wmem   = r_wmem;
    assign pipe.e_aluc   = r_aluc;
    assign pipe.e_aluimm = r_aluimm;

`ifdef STALL_CNT_EN
    // Count events that actually take effect at this edge (not masked by hold,
    // and for load-use not overridden by a flush).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_lu    <= '0;
            cnt_flush <= '0;
        end else begin
            if (w_lu && !ex_hold && !flush) begin
                cnt_lu <= cnt_lu + 32'd1;
            end
            if (flush && !ex_hold) begin
                cnt_flush <= cnt_flush + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed scenarios for
//               forwarding priority, load-use, flush, hold and asynchronous
//               reset, followed by randomized traffic checked against a
//               behavioural model of the stage.
// Options     : STALL_CNT_EN - also checks cnt_lu / cnt_flush
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] qa, qb, ex_r, m_d, w_d;
    logic [4:0]  m_wn, w_wn;
    logic        m_we, w_we, flush, ex_hold;
    logic        stall;
`ifdef STALL_CNT_EN
    logic [31:0] cnt_lu, cnt_flush;
`endif

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk       (clk),
        .clrn      (clrn),
        .pipe      (bus),
        .qa        (qa),
        .qb        (qb),
        .ex_r      (ex_r),
        .m_wn      (m_wn),
        .m_we      (m_we),
        .m_d       (m_d),
        .w_wn      (w_wn),
        .w_we      (w_we),
        .w_d       (w_d),
        .flush     (flush),
        .ex_hold   (ex_hold),
        .stall     (stall)
`ifdef STALL_CNT_EN
        ,
        .cnt_lu    (cnt_lu),
        .cnt_flush (cnt_flush)
`endif
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic        valid;
        logic [31:0] a, b, st, imm;
        logic [4:0]  wn;
        logic        we, m2reg, wmem;
        logic [3:0]  aluc;
        logic        aluimm;
    } ex_t;

    ex_t         m, nxt;
    logic        exp_stall;
    logic        last_stall;
    logic [31:0] exp_cnt_lu = 0, exp_cnt_fl = 0, nxt_cnt_lu, nxt_cnt_fl;
    int          n_vec = 0;
    int          n_err = 0;
    string       phase = "reset";

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL [%s] %s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    // Newest-to-oldest list of in-flight producers; first matching writer wins
    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        logic        en [3];
        logic [4:0]  wn [3];
        logic [31:0] v  [3];
        en = '{m.valid && m.we, m_we, w_we};
        wn = '{m.wn, m_wn, w_wn};
        v  = '{ex_r, m_d, w_d};
        if (r == 5'd0) return 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (en[i] && wn[i] == r) return v[i];
        end
        return rf;
    endfunction

    task automatic predict();
        logic        lu;
        logic [31:0] fb;
        lu = bus.d_valid && m.valid && m.m2reg && m.we && (m.wn != 5'd0)
             && ((bus.use_rs && m.wn == bus.rs) || (bus.use_rt && m.wn == bus.rt));
        exp_stall  = (lu || ex_hold) && !flush;
        nxt_cnt_lu = exp_cnt_lu + ((lu && !ex_hold && !flush) ? 32'd1 : 32'd0);
        nxt_cnt_fl = exp_cnt_fl + ((flush && !ex_hold) ? 32'd1 : 32'd0);
        if (ex_hold) begin
            nxt = m;
        end else if (flush || lu) begin
            nxt = '0;
        end else begin
            fb         = resolve(bus.rt, qb);
            nxt.valid  = bus.d_valid;
            nxt.a      = resolve(bus.rs, qa);
            nxt.b      = bus.d_aluimm ? bus.d_imm : fb;
            nxt.st     = fb;
            nxt.imm    = bus.d_imm;
            nxt.wn     = bus.d_wn;
            nxt.we     = bus.d_we && bus.d_valid;
            nxt.m2reg  = bus.d_m2reg;
            nxt.wmem   = bus.d_wmem && bus.d_valid;
            nxt.aluc   = bus.d_aluc;
            nxt.aluimm = bus.d_aluimm;
        end
    endtask

    task automatic check_outputs();
        check_val("e_valid",  64'(bus.e_valid),  64'(m.valid));
        check_val("e_a",      64'(bus.e_a),      64'(m.a));
        check_val("e_b",      64'(bus.e_b),      64'(m.b));
        check_val("e_st",     64'(bus.e_st),     64'(m.st));
        check_val("e_imm",    64'(bus.e_imm),    64'(m.imm));
        check_val("e_wn",     64'(bus.e_wn),     64'(m.wn));
        check_val("e_we",     64'(bus.e_we),     64'(m.we));
        check_val("e_m2reg",  64'(bus.e_m2reg),  64'(m.m2reg));
        check_val("e_wmem",   64'(bus.e_wmem),   64'(m.wmem));
        check_val("e_aluc",   64'(bus.e_aluc),   64'(m.aluc));
        check_val("e_aluimm", 64'(bus.e_aluimm), 64'(m.aluimm));
`ifdef STALL_CNT_EN
        check_val("cnt_lu",    64'(cnt_lu),    64'(exp_cnt_lu));
        check_val("cnt_flush", 64'(cnt_flush), 64'(exp_cnt_fl));
`endif
    endtask

    // Inputs are already applied (just after a rising edge); check stall
    // mid-cycle, clock once, then check the registered fields.
    task automatic step();
        #2;
        predict();
        last_stall = stall;
        check_val("stall", 64'(stall), 64'(exp_stall));
        @(posedge clk);
        #1;
        m          = nxt;
        exp_cnt_lu = nxt_cnt_lu;
        exp_cnt_fl = nxt_cnt_fl;
        check_outputs();
    endtask

    task automatic idle();
        bus.d_valid = 0; bus.rs = 0; bus.rt = 0; bus.use_rs = 0; bus.use_rt = 0;
        bus.d_wn = 0; bus.d_we = 0; bus.d_m2reg = 0; bus.d_wmem = 0;
        bus.d_aluc = 0; bus.d_aluimm = 0; bus.d_imm = 0;
        qa = 0; qb = 0; ex_r = 0; m_d = 0; w_d = 0;
        m_wn = 0; w_wn = 0; m_we = 0; w_we = 0; flush = 0; ex_hold = 0;
    endtask

    task automatic rand_inputs();
        bus.d_valid  = ($urandom_range(0, 3) != 0);
        bus.rs       = 5'($urandom_range(0, 7));
        bus.rt       = 5'($urandom_range(0, 7));
        bus.use_rs   = $urandom_range(0, 1) != 0;
        bus.use_rt   = $urandom_range(0, 1) != 0;
        bus.d_wn     = 5'($urandom_range(0, 7));
        bus.d_we     = ($urandom_range(0, 3) != 0);
        bus.d_m2reg  = ($urandom_range(0, 2) == 0);
        bus.d_wmem   = ($urandom_range(0, 3) == 0);
        bus.d_aluc   = 4'($urandom_range(0, 15));
        bus.d_aluimm = $urandom_range(0, 1) != 0;
        bus.d_imm    = $urandom;
        qa = $urandom; qb = $urandom; ex_r = $urandom; m_d = $urandom; w_d = $urandom;
        m_wn = 5'($urandom_range(0, 7));
        w_wn = 5'($urandom_range(0, 7));
        m_we = $urandom_range(0, 1) != 0;
        w_we = $urandom_range(0, 1) != 0;
        flush   = ($urandom_range(0, 7) == 0);
        ex_hold = ($urandom_range(0, 7) == 0);
    endtask

    task automatic load_to_ex(input logic [4:0] wn, input logic is_load, input logic we);
        idle();
        bus.d_valid = 1; bus.d_wn = wn; bus.d_we = we; bus.d_m2reg = is_load;
        bus.d_aluc = ALU_ADD;
        step();
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        idle();
        m = '0;
        #12;
        check_outputs();
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        phase = "ex_fwd";
        load_to_ex(5'd3, 1'b0, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 3; bus.use_rs = 1; bus.d_we = 1; bus.d_wn = 6;
        bus.d_aluc = ALU_SUB; ex_r = 32'h11; qa = 32'h99;
        step();
        check_val("exfwd_e_a", 64'(bus.e_a), 64'h11);
        check_val("exfwd_stall", 64'(last_stall), 64'h0);

        phase = "priority";
        load_to_ex(5'd5, 1'b0, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 5; bus.use_rs = 1; bus.d_we = 0; bus.d_wn = 5;
        ex_r = 32'hA; m_we = 1; m_wn = 5; m_d = 32'hB; w_we = 1; w_wn = 5; w_d = 32'hC;
        qa = 32'h77;
        step();
        check_val("prio_ex", 64'(bus.e_a), 64'hA);
        step();   // EX now holds the non-writing copy
        check_val("prio_mem", 64'(bus.e_a), 64'hB);

        phase = "wb_same_cycle";
        idle();
        bus.d_valid = 1; bus.rt = 7; bus.use_rt = 1; w_we = 1; w_wn = 7; w_d = 32'hDEAD; qb = 0;
        step();
        check_val("wb_e_st", 64'(bus.e_st), 64'hDEAD);

        phase = "load_use";
        load_to_ex(5'd4, 1'b1, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 4; bus.use_rs = 1; bus.d_we = 1; bus.d_wn = 8; qa = 32'h99;
        step();
        check_val("lu_stall", 64'(last_stall), 64'h1);
        check_val("lu_bubble", 64'(bus.e_valid), 64'h0);
        m_we = 1; m_wn = 4; m_d = 32'h55;
        step();
        check_val("lu_retry_stall", 64'(last_stall), 64'h0);
        check_val("lu_retry_e_a", 64'(bus.e_a), 64'h55);
        load_to_ex(5'd4, 1'b1, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 4; bus.use_rs = 0; qa = 32'h99;
        step();
        check_val("nouse_stall", 64'(last_stall), 64'h0);
        check_val("nouse_valid", 64'(bus.e_valid), 64'h1);

        phase = "flush_lu";
        load_to_ex(5'd4, 1'b1, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 4; bus.use_rs = 1; flush = 1;
        step();
        check_val("flush_stall", 64'(last_stall), 64'h0);
        check_val("flush_bubble", 64'(bus.e_valid), 64'h0);

        phase = "ex_hold";
        idle();
        bus.d_valid = 1; bus.d_we = 1; bus.d_wn = 9; bus.rs = 2; bus.use_rs = 1;
        qa = 32'h1357; bus.d_imm = 32'h2468;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            ex_hold = 1; flush = 0;
            step();
            check_val("hold_stall", 64'(last_stall), 64'h1);
            check_val("hold_e_a", 64'(bus.e_a), 64'h1357);
        end

        phase = "r0";
        load_to_ex(5'd0, 1'b0, 1'b1);
        idle();
        bus.d_valid = 1; bus.rs = 0; bus.use_rs = 1; qa = 32'h1234;
        ex_r = 32'h1; m_we = 1; m_wn = 0; m_d = 32'h2; w_we = 1; w_wn = 0; w_d = 32'h3;
        step();
        check_val("r0_e_a", 64'(bus.e_a), 64'h0);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        phase = "async_reset";
        load_to_ex(5'd3, 1'b0, 1'b1);
        check_val("pre_reset_valid", 64'(bus.e_valid), 64'h1);
        #2;
        clrn = 1'b0;
        #1;
        m = '0; exp_cnt_lu = 0; exp_cnt_fl = 0;
        check_outputs();
        idle();
        #3;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        phase = "post_reset";
        for (int i = 0; i < 50; i++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
